// File: rtl/freq_meas_ctrl.sv
// Reciprocal frequency-measurement sequencer: arms on start, opens a gate on a
// signal rising edge, counts clk cycles and signal edges, and closes on a signal edge.
module freq_meas_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 100000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] gate_cycles,
   input  logic             sig_in,
   input  logic             result_ack,
   output logic             busy,
   output logic             gate_open,
   output logic             result_valid,
   output logic             timeout,
   output logic             overflow,
   output logic [CNT_W-1:0] ref_count,
   output logic [CNT_W-1:0] sig_count
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int EL_W  = ((CNT_W > TMO_W) ? CNT_W : TMO_W) + 1;
   localparam logic [EL_W-1:0]  TMO_LIM = EL_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
   state_t state_reg, state_next;

   logic             sync1_reg, sync2_reg, edge_reg;
   logic             sig_rise;
   logic [CNT_W-1:0] gate_reg, gate_next;
   logic [CNT_W-1:0] ref_cnt_reg, ref_cnt_next;
   logic [CNT_W-1:0] sig_cnt_reg, sig_cnt_next;
   logic [CNT_W-1:0] ref_count_reg, ref_count_next;
   logic [CNT_W-1:0] sig_count_reg, sig_count_next;
   logic             timeout_reg, timeout_next;
   logic             overflow_reg, overflow_next;
   // Unsaturated elapsed-cycle counter: ARM wait time, then GATE length for the abort limit
   logic [EL_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
   logic [EL_W-1:0]  tmo_inc, gate_lim;
   logic [CNT_W-1:0] ref_inc, sig_inc;
   logic             ref_sat, sig_sat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         edge_reg  <= 1'b0;
      end else begin
         sync1_reg <= sig_in;
         sync2_reg <= sync1_reg;
         edge_reg  <= sync2_reg;
      end
   end

   assign sig_rise = sync2_reg & ~edge_reg;

   assign ref_sat  = (ref_cnt_reg == CNT_MAX);
   assign ref_inc  = ref_sat ? ref_cnt_reg : ref_cnt_reg + CNT_W'(1);
   assign sig_sat  = sig_rise && (sig_cnt_reg == CNT_MAX);
   assign sig_inc  = (sig_rise && !sig_sat) ? sig_cnt_reg + CNT_W'(1) : sig_cnt_reg;
   assign tmo_inc  = tmo_cnt_reg + EL_W'(1);
   assign gate_lim = EL_W'(gate_reg) + TMO_LIM;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         gate_reg      <= '0;
         ref_cnt_reg   <= '0;
         sig_cnt_reg   <= '0;
         ref_count_reg <= '0;
         sig_count_reg <= '0;
         timeout_reg   <= 1'b0;
         overflow_reg  <= 1'b0;
         tmo_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         gate_reg      <= gate_next;
         ref_cnt_reg   <= ref_cnt_next;
         sig_cnt_reg   <= sig_cnt_next;
         ref_count_reg <= ref_count_next;
         sig_count_reg <= sig_count_next;
         timeout_reg   <= timeout_next;
         overflow_reg  <= overflow_next;
         tmo_cnt_reg   <= tmo_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      gate_next      = gate_reg;
      ref_cnt_next   = ref_cnt_reg;
      sig_cnt_next   = sig_cnt_reg;
      ref_count_next = ref_count_reg;
      sig_count_next = sig_count_reg;
      timeout_next   = timeout_reg;
      overflow_next  = overflow_reg;
      tmo_cnt_next   = tmo_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               gate_next     = (gate_cycles == '0) ? CNT_W'(1) : gate_cycles;
               tmo_cnt_next  = '0;
               timeout_next  = 1'b0;
               overflow_next = 1'b0;
               state_next    = ARM;
            end
         end
         ARM: begin
            tmo_cnt_next = tmo_inc;
            if (sig_rise) begin
               ref_cnt_next  = '0;
               sig_cnt_next  = '0;
               overflow_next = 1'b0;
               tmo_cnt_next  = '0;
               state_next    = GATE;
            end else if (tmo_inc >= TMO_LIM) begin
               ref_count_next = '0;
               sig_count_next = '0;
               timeout_next   = 1'b1;
               state_next     = DONE;
            end
         end
         GATE: begin
            ref_cnt_next = ref_inc;
            sig_cnt_next = sig_inc;
            tmo_cnt_next = tmo_inc;
            if (ref_sat || sig_sat) overflow_next = 1'b1;
            // A closing edge wins over the abort limit in the same cycle
            if (sig_rise && (ref_inc >= gate_reg)) begin
               ref_count_next = ref_inc;
               sig_count_next = sig_inc;
               state_next     = DONE;
            end else if (tmo_inc >= gate_lim) begin
               ref_count_next = ref_inc;
               sig_count_next = sig_inc;
               timeout_next   = 1'b1;
               state_next     = DONE;
            end
         end
         DONE: begin
            if (result_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy         = (state_reg == ARM) || (state_reg == GATE);
   assign gate_open    = (state_reg == GATE);
   assign result_valid = (state_reg == DONE);
   assign timeout      = timeout_reg;
   assign overflow     = overflow_reg;
   assign ref_count    = ref_count_reg;
   assign sig_count    = sig_count_reg;
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: directed and random measurements compared against
// an arithmetic model of whole signal periods inside the gate.
module tb_freq_meas_ctrl;
   localparam int CNT_W = 8;
   localparam int TMO   = 1000;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset, start, sig_in, result_ack;
   logic [CNT_W-1:0] gate_cycles;
   logic             busy, gate_open, result_valid, timeout, overflow;
   logic [CNT_W-1:0] ref_count, sig_count;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int sig_per = 0;

   freq_meas_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .gate_cycles(gate_cycles),
      .sig_in(sig_in), .result_ack(result_ack), .busy(busy), .gate_open(gate_open),
      .result_valid(result_valid), .timeout(timeout), .overflow(overflow),
      .ref_count(ref_count), .sig_count(sig_count)
   );

   always #5 clk = ~clk;

   // Periodic test signal, high for per/2 clk cycles of every per; 0 stops it low
   initial begin
      int ph;
      ph = 0;
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         if (sig_per == 0) begin
            sig_in = 1'b0;
            ph = 0;
         end else begin
            ph = (ph + 1) % sig_per;
            sig_in = (ph < sig_per / 2);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // The gate covers the fewest whole periods whose length reaches the preset
   function automatic void model(input int gc, input int per,
                                 output int eref, output int esig, output int eovf);
      int g, k;
      g    = (gc == 0) ? 1 : gc;
      k    = (g + per - 1) / per;
      eref = (k * per > MAXC) ? MAXC : k * per;
      esig = (k > MAXC) ? MAXC : k;
      eovf = (k * per > MAXC || k > MAXC) ? 1 : 0;
   endfunction

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!result_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done_in_time"}, n < 3000, 1);
   endtask

   task automatic do_ack(input string tag);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk({tag, " valid_after_ack"}, result_valid, 0);
      chk({tag, " busy_after_ack"}, busy, 0);
   endtask

   task automatic run_meas(input string tag, input int gc, input int per, input bit pester);
      int eref, esig, eovf, n;
      sig_per = per;
      repeat (30) @(negedge clk);
      gate_cycles = CNT_W'(gc);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy"}, busy, 1);
      n = 0;
      while (!result_valid && n < 3000) begin
         if (pester) begin
            start       = 1'b1;
            result_ack  = 1'b1;
            gate_cycles = CNT_W'($urandom_range(0, MAXC));
         end
         @(negedge clk);
         start      = 1'b0;
         result_ack = 1'b0;
         n++;
      end
      chk({tag, " done_in_time"}, n < 3000, 1);
      model(gc, per, eref, esig, eovf);
      $display("meas %s: gate=%0d per=%0d ref=%0d sig=%0d ovf=%0d tmo=%0d", tag, gc, per,
               ref_count, sig_count, overflow, timeout);
      chk({tag, " ref_count"}, ref_count, eref);
      chk({tag, " sig_count"}, sig_count, esig);
      chk({tag, " overflow"}, overflow, eovf);
      chk({tag, " timeout"}, timeout, 0);
      chk({tag, " gate_closed"}, gate_open, 0);
      if (pester) begin
         repeat (50) begin
            start       = 1'b1;
            gate_cycles = CNT_W'($urandom_range(0, MAXC));
            @(negedge clk);
            start = 1'b0;
         end
         chk({tag, " held_valid"}, result_valid, 1);
         chk({tag, " held_ref"}, ref_count, eref);
         chk({tag, " held_sig"}, sig_count, esig);
      end
      do_ack(tag);
   endtask

   initial begin
      int n, gc, per;
      reset = 1'b0; start = 1'b0; result_ack = 1'b0; gate_cycles = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst valid", result_valid, 0);
      chk("rst ref", ref_count, 0);
      chk("rst sig", sig_count, 0);
      chk("rst timeout", timeout, 0);
      reset = 1'b1;

      run_meas("nominal", 95, 10, 1'b1);
      run_meas("edge100", 100, 10, 1'b0);
      run_meas("edge101", 101, 10, 1'b0);
      run_meas("gate0", 0, 7, 1'b0);
      run_meas("saturate", 255, 10, 1'b0);

      // No signal: abort exactly TIMEOUT cycles after ARM is entered
      sig_per = 0;
      repeat (5) @(negedge clk);
      gate_cycles = 8'd50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("nosig busy", busy, 1);
      n = 0;
      while (!result_valid && n < 5000) begin
         @(negedge clk);
         n++;
      end
      $display("meas nosig: cycles=%0d tmo=%0d ref=%0d sig=%0d", n, timeout, ref_count, sig_count);
      chk("nosig cycles", n, TMO);
      chk("nosig timeout", timeout, 1);
      chk("nosig ref", ref_count, 0);
      chk("nosig sig", sig_count, 0);
      do_ack("nosig");

      // Signal stops 35 cycles into the gate: three edges counted, ref saturates
      sig_per = 10;
      repeat (30) @(negedge clk);
      gate_cycles = 8'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!gate_open && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("stop gate_opened", n < 100, 1);
      repeat (35) @(negedge clk);
      sig_per = 0;
      wait_valid("stop");
      $display("meas stop: tmo=%0d ref=%0d sig=%0d ovf=%0d", timeout, ref_count, sig_count, overflow);
      chk("stop timeout", timeout, 1);
      chk("stop sig", sig_count, 3);
      chk("stop ref", ref_count, MAXC);
      chk("stop overflow", overflow, 1);
      do_ack("stop");

      // Reset in the middle of a gate clears everything at once
      sig_per = 10;
      repeat (30) @(negedge clk);
      gate_cycles = 8'd150; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!gate_open && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midrst gate_opened", n < 100, 1);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      $display("reset mid-gate: busy=%0d gate=%0d ref=%0d tmo=%0d", busy, gate_open, ref_count, timeout);
      chk("midrst busy", busy, 0);
      chk("midrst gate_open", gate_open, 0);
      chk("midrst valid", result_valid, 0);
      chk("midrst timeout", timeout, 0);
      chk("midrst overflow", overflow, 0);
      chk("midrst ref", ref_count, 0);
      chk("midrst sig", sig_count, 0);
      @(negedge clk);
      reset = 1'b1;
      run_meas("after_rst", 60, 9, 1'b0);

      for (int i = 0; i < 8; i++) begin
         gc  = $urandom_range(0, 240);
         per = $urandom_range(4, 24);
         run_meas($sformatf("rand%0d", i), gc, per, i[0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
